vga_timing_generator: RTL and testbench
=======================================

// Module: vga_timing_generator
// PURPOSE
//  Master VGA 640x480@60 timing source, one stage upstream of the text-mode pixel generator.
//  Divides the 100 MHz clk into 4 sub-pixel phases (TEXT_FETCH/GLYPH_FETCH/WAIT/DRAW) per 25 MHz pixel.
//  Drives pixel/line counters plus the phase to the pixel generator; drives hsync/vsync/video_on,
//  aligned to the generator's registered color, to the DAC/connector.
// PARAMETERS
//  SUB_PIXEL_WIDTH  2    sub-pixel phase counter width (2**W clk per pixel)
//  PIXEL_WIDTH      10   pixel_counter width
//  LINE_WIDTH       10   line_counter width
//  H_VISIBLE 640, H_FP 16, H_SYNC 96, H_BP 48    horizontal regions in pixels (total 800)
//  V_VISIBLE 480, V_FP 10, V_SYNC 2,  V_BP 33    vertical regions in lines (total 525)
//  SYNC_ACTIVE      1'b0 sync pulse level (negative polarity for 640x480)
// PORTS
//  clk            in   1   system clock, 100 MHz
//  reset          in   1   synchronous, active-high
//  enable         in   1   run timing; low = hold at frame origin
//  pixel_counter  out  10  current pixel, 0..799
//  line_counter   out  10  current line, 0..524 (pixel generator uses [8:0], valid while visible)
//  pixel_state    out  2   sub-pixel phase: 0 TEXT_FETCH, 1 GLYPH_FETCH, 2 WAIT, 3 DRAW
//  hsync          out  1   horizontal sync, SYNC_ACTIVE during pulse
//  vsync          out  1   vertical sync, SYNC_ACTIVE during pulse
//  video_on       out  1   high while displayed pixel is in visible region
//  frame_start    out  1   one-clk frame strobe (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (or enable low): pixel_state=0, pixel_counter=0, line_counter=0, hsync=vsync=~SYNC_ACTIVE,
//    video_on=0, frame_start=0. Held there every clk while asserted; reset has priority over enable.
//  - All outputs registered. pixel_state increments every clk, wraps 3->0.
//  - On the clk where pixel_state==3: pixel_counter increments; at 799 it wraps to 0 and line_counter
//    increments; line_counter wraps 524->0 when pixel_counter wraps at 799.
//  - Counters and phase change on the same edge, so (pixel,line) stays constant across phases 0..3.
//  - Sync/blank alignment: the pixel generator updates color on the edge ending DRAW. hsync, vsync and
//    video_on update on that same edge (pixel_state==3), computed from the pre-increment counters:
//      hsync active iff 656 <= pixel <= 751; vsync active iff 490 <= line <= 491;
//      video_on iff pixel < 640 && line < 480.
//    Net: one pixel (4 clk) latency from counters to sync, identical to color latency.
//  - Region bounds derive from parameters (H_VISIBLE+H_FP etc.); comparisons at full counter width,
//    no truncation; totals must fit PIXEL_WIDTH/LINE_WIDTH.
//  - enable falling mid-frame: next edge returns to origin (restart, not pause). enable rising: frame
//    restarts at (0,0) phase 0; first hsync at pixel 656 of line 0.
//  - reset mid-line: same as enable low; no partial sync pulse survives reset.
// CONFIGURATION
//  - VGA_FRAME_STROBE_EN defined: frame_start pulses high for exactly one clk on the edge where
//    pixel_state goes 3->0 and both counters wrap to (0,0); never during reset/enable low, nor on
//    enable rising.
//  - Not defined: frame_start tied 1'b0; no strobe logic synthesized; port list unchanged.
// STRUCTURE
//  - Shared package vga_pkg: pixel_state encodings (TEXT_FETCH..DRAW), 640x480 timing constants,
//    counter width constants; also imported by pixel_generator.
//  - One sub-module: vga_wrap_counter (WIDTH, MAX; inputs clk, reset, clear, inc; outputs count, wrap),
//    instantiated three times: phase (MAX=3), pixel (MAX=799), line (MAX=524), chained on wrap.
//  - Sync/blank decode plus output register: in this module.
// TESTING
//  - Reset 3 clk then release, enable=1 -> pixel_state 0,1,2,3,0...; pixel_counter 0->1 on 4th edge.
//  - Run one line -> pixel 799 phase 3 wraps to pixel 0, line 1; line period exactly 3200 clk.
//  - hsync: goes active on the edge ending DRAW of pixel 656, inactive after pixel 751 (384 clk wide);
//    video_on falls after pixel 639, rises after pixel 0 of next line.
//  - Full frame -> vsync active lines 490..491 (6400 clk), frame period 1,680,000 clk, line wraps 524->0.
//  - enable low at line 100 pixel 300 -> next edge at origin, syncs inactive; re-enable -> count from 0.
//  - With VGA_FRAME_STROBE_EN: exactly one frame_start pulse per 1,680,000 clk; none after reset;
//    without the macro frame_start stays 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: sub-pixel phase encodings, 640x480@60 timing
// constants and counter widths. Also imported by the text-mode pixel generator.
package vga_pkg;

   // Sub-pixel phases within one 25 MHz pixel (four 100 MHz clocks)
   typedef enum logic [1:0] {
      TEXT_FETCH  = 2'd0,
      GLYPH_FETCH = 2'd1,
      WAIT        = 2'd2,
      DRAW        = 2'd3
   } pixel_state_e;

   localparam int VGA_SUB_PIXEL_WIDTH = 2;
   localparam int VGA_PIXEL_WIDTH     = 10;
   localparam int VGA_LINE_WIDTH      = 10;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FP      = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BP      = 48;

   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FP      = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BP      = 33;

   // 640x480 uses negative sync polarity
   localparam logic VGA_SYNC_ACTIVE = 1'b0;

   // Inclusive window test done at 32 bits so no counter value is truncated
   function automatic logic in_window(input int unsigned v,
                                      input int unsigned lo,
                                      input int unsigned hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-(MAX+1) counter with a combinational wrap flag so several
// instances can be chained (phase -> pixel -> line).
module vga_wrap_counter #(
   parameter int WIDTH = 10,
   parameter int MAX   = 799
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: advance on inc, return to zero after MAX
   always_comb begin
      wrap    = inc && (count_q == MAX_C);
      count_d = count_q;
      if (inc) begin
         count_d = wrap ? '0 : count_q + 1'b1;
      end
   end

   // Count register; reset and clear both force zero
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA timing master: sub-pixel phase, pixel and line counters plus
// hsync/vsync/video_on aligned to the pixel generator's colour register.
// Optional feature macro: VGA_FRAME_STROBE_EN enables the frame_start strobe;
// without it frame_start is tied low.
module vga_timing_generator
   import vga_pkg::*;
#(
   parameter int   SUB_PIXEL_WIDTH = VGA_SUB_PIXEL_WIDTH,
   parameter int   PIXEL_WIDTH     = VGA_PIXEL_WIDTH,
   parameter int   LINE_WIDTH      = VGA_LINE_WIDTH,
   parameter int   H_VISIBLE       = VGA_H_VISIBLE,
   parameter int   H_FP            = VGA_H_FP,
   parameter int   H_SYNC          = VGA_H_SYNC,
   parameter int   H_BP            = VGA_H_BP,
   parameter int   V_VISIBLE       = VGA_V_VISIBLE,
   parameter int   V_FP            = VGA_V_FP,
   parameter int   V_SYNC          = VGA_V_SYNC,
   parameter int   V_BP            = VGA_V_BP,
   parameter logic SYNC_ACTIVE     = VGA_SYNC_ACTIVE
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   output logic [PIXEL_WIDTH-1:0]     pixel_counter,
   output logic [LINE_WIDTH-1:0]      line_counter,
   output logic [SUB_PIXEL_WIDTH-1:0] pixel_state,
   output logic                       hsync,
   output logic                       vsync,
   output logic                       video_on,
   output logic                       frame_start
);

   localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_VISIBLE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_VISIBLE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   logic phase_wrap;
   logic pixel_wrap;
   logic line_wrap;
   logic hold;

   // enable low restarts the frame rather than pausing it
   assign hold = ~enable;

   vga_wrap_counter #(.WIDTH(SUB_PIXEL_WIDTH), .MAX((2 ** SUB_PIXEL_WIDTH) - 1)) u_phase (
      .clk   (clk),
      .reset (reset),
      .clear (hold),
      .inc   (1'b1),
      .count (pixel_state),
      .wrap  (phase_wrap)
   );

   vga_wrap_counter #(.WIDTH(PIXEL_WIDTH), .MAX(H_TOTAL - 1)) u_pixel (
      .clk   (clk),
      .reset (reset),
      .clear (hold),
      .inc   (phase_wrap),
      .count (pixel_counter),
      .wrap  (pixel_wrap)
   );

   vga_wrap_counter #(.WIDTH(LINE_WIDTH), .MAX(V_TOTAL - 1)) u_line (
      .clk   (clk),
      .reset (reset),
      .clear (hold),
      .inc   (pixel_wrap),
      .count (line_counter),
      .wrap  (line_wrap)
   );

   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic video_on_q, video_on_d;

   // Decode sync/blank from the pre-increment counters; update only as DRAW ends
   always_comb begin
      hsync_d    = hsync_q;
      vsync_d    = vsync_q;
      video_on_d = video_on_q;
      if (phase_wrap) begin
         hsync_d = in_window(32'(pixel_counter), H_SYNC_START, H_SYNC_END)
                   ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync_d = in_window(32'(line_counter), V_SYNC_START, V_SYNC_END)
                   ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         video_on_d = (32'(pixel_counter) < H_VISIBLE) && (32'(line_counter) < V_VISIBLE);
      end
   end

   // Sync/blank output registers; reset or hold forces inactive levels
   always_ff @(posedge clk) begin
      if (reset || hold) begin
         hsync_q    <= ~SYNC_ACTIVE;
         vsync_q    <= ~SYNC_ACTIVE;
         video_on_q <= 1'b0;
      end else begin
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
      end
   end

   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign video_on = video_on_q;

`ifdef VGA_FRAME_STROBE_EN
   logic frame_start_q;

   // One-clock strobe on the edge where the whole frame wraps to (0,0)
   always_ff @(posedge clk) begin
      if (reset || hold) begin
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= line_wrap;
      end
   end

   assign frame_start = frame_start_q;
`else
   logic line_wrap_unused;

   assign line_wrap_unused = line_wrap;
   assign frame_start      = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: full-width horizontal timing, shortened
// vertical timing (9 lines) so whole frames fit in a short run.
// Optional feature macro: VGA_FRAME_STROBE_EN (bench follows the same build).
module tb_vga_timing_generator;

   localparam int TB_H_VIS  = 640;
   localparam int TB_H_FP   = 16;
   localparam int TB_H_SYNC = 96;
   localparam int TB_H_BP   = 48;
   localparam int TB_V_VIS  = 4;
   localparam int TB_V_FP   = 1;
   localparam int TB_V_SYNC = 2;
   localparam int TB_V_BP   = 2;
   localparam int TB_HT     = 800;
   localparam int TB_VT     = 9;
   localparam int TB_FRAME  = TB_HT * TB_VT * 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [9:0] pixel_counter;
   logic [9:0] line_counter;
   logic [1:0] pixel_state;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       frame_start;

   always #5 clk = ~clk;

   vga_timing_generator #(
      .H_VISIBLE (TB_H_VIS),
      .H_FP      (TB_H_FP),
      .H_SYNC    (TB_H_SYNC),
      .H_BP      (TB_H_BP),
      .V_VISIBLE (TB_V_VIS),
      .V_FP      (TB_V_FP),
      .V_SYNC    (TB_V_SYNC),
      .V_BP      (TB_V_BP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .pixel_counter (pixel_counter),
      .line_counter  (line_counter),
      .pixel_state   (pixel_state),
      .hsync         (hsync),
      .vsync         (vsync),
      .video_on      (video_on),
      .frame_start   (frame_start)
   );

   typedef struct {
      int   ph;
      int   pix;
      int   ln;
      logic hs;
      logic vs;
      logic von;
      logic fs;
   } exp_t;

   exp_t sb_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // reference model state
   int   m_ph = 0, m_pix = 0, m_ln = 0;
   logic m_hs = 1'b1, m_vs = 1'b1, m_von = 1'b0, m_fs = 1'b0;

   // statistics gathered while stepping
   int hs_low_clk = 0, vs_low_clk = 0, fs_count = 0;
   int fs_cyc_first = -1, fs_cyc_second = -1;
   int prev_line = 0, line1_cyc = -1, line2_cyc = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Model one clock edge from the current reset/enable inputs
   task automatic model_tick();
      if (reset || !enable) begin
         m_ph = 0; m_pix = 0; m_ln = 0;
         m_hs = 1'b1; m_vs = 1'b1; m_von = 1'b0; m_fs = 1'b0;
      end else begin
         m_fs = 1'b0;
         if (m_ph == 3) begin
            m_hs  = (m_pix >= TB_H_VIS + TB_H_FP && m_pix < TB_H_VIS + TB_H_FP + TB_H_SYNC) ? 1'b0 : 1'b1;
            m_vs  = (m_ln >= TB_V_VIS + TB_V_FP && m_ln < TB_V_VIS + TB_V_FP + TB_V_SYNC) ? 1'b0 : 1'b1;
            m_von = (m_pix < TB_H_VIS) && (m_ln < TB_V_VIS);
`ifdef VGA_FRAME_STROBE_EN
            m_fs  = (m_pix == TB_HT - 1) && (m_ln == TB_VT - 1);
`endif
            if (m_pix == TB_HT - 1) begin
               m_pix = 0;
               m_ln  = (m_ln == TB_VT - 1) ? 0 : m_ln + 1;
            end else begin
               m_pix = m_pix + 1;
            end
            m_ph = 0;
         end else begin
            m_ph = m_ph + 1;
         end
      end
   endtask

   // Push expectation, clock once, pop and compare every output
   task automatic step();
      exp_t e;
      model_tick();
      e = '{m_ph, m_pix, m_ln, m_hs, m_vs, m_von, m_fs};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      e = sb_q.pop_front();
      chk("pixel_state", 32'(pixel_state), 32'(e.ph));
      chk("pixel_counter", 32'(pixel_counter), 32'(e.pix));
      chk("line_counter", 32'(line_counter), 32'(e.ln));
      chk("hsync", 32'(hsync), 32'(e.hs));
      chk("vsync", 32'(vsync), 32'(e.vs));
      chk("video_on", 32'(video_on), 32'(e.von));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      if (hsync == 1'b0) hs_low_clk++;
      if (vsync == 1'b0) vs_low_clk++;
      if (frame_start == 1'b1) begin
         fs_count++;
         if (fs_cyc_first < 0) fs_cyc_first = cyc;
         else if (fs_cyc_second < 0) fs_cyc_second = cyc;
      end
      if (int'(line_counter) != prev_line) begin
         if (int'(line_counter) == 1 && line1_cyc < 0) line1_cyc = cyc;
         if (int'(line_counter) == 2 && line2_cyc < 0) line2_cyc = cyc;
      end
      prev_line = int'(line_counter);
   endtask

   initial begin
      int guard;
      reset  = 1'b1;
      enable = 1'b1;
      repeat (3) step();
      chk("reset_pixel_state", 32'(pixel_state), 32'd0);
      chk("reset_hsync", 32'(hsync), 32'd1);
      chk("reset_vsync", 32'(vsync), 32'd1);

      // release: pixel counter moves 0->1 on the 4th edge
      reset = 1'b0;
      repeat (3) step();
      chk("pix_before_4th_edge", 32'(pixel_counter), 32'd0);
      step();
      chk("pix_after_4th_edge", 32'(pixel_counter), 32'd1);

      // two complete frames measured from the release
      hs_low_clk = 0; vs_low_clk = 0; fs_count = 0;
      repeat (2 * TB_FRAME - 4) step();
      chk("line_period_clk", 32'(line2_cyc - line1_cyc), 32'(TB_HT * 4));
      chk("hsync_low_clk_2frames", 32'(hs_low_clk), 32'(2 * TB_VT * TB_H_SYNC * 4));
      chk("vsync_low_clk_2frames", 32'(vs_low_clk), 32'(2 * TB_V_SYNC * TB_HT * 4));
      chk("back_at_origin_line", 32'(line_counter), 32'd0);
`ifdef VGA_FRAME_STROBE_EN
      chk("frame_start_count", 32'(fs_count), 32'd2);
      chk("frame_period_clk", 32'(fs_cyc_second - fs_cyc_first), 32'(TB_FRAME));
`else
      chk("frame_start_count", 32'(fs_count), 32'd0);
`endif

      // enable drop mid-frame restarts from origin
      guard = 0;
      while (!(line_counter == 10'd2 && pixel_counter == 10'd300) && guard < 40000) begin
         step();
         guard++;
      end
      chk("reached_line2_pix300", 32'(guard < 40000), 32'd1);
      enable = 1'b0;
      step();
      chk("disable_pixel", 32'(pixel_counter), 32'd0);
      chk("disable_line", 32'(line_counter), 32'd0);
      step();
      enable = 1'b1;
      fs_count = 0;
      repeat (TB_HT * 4) step();
      chk("reenable_line1", 32'(line_counter), 32'd1);
      chk("no_strobe_on_enable", 32'(fs_count), 32'd0);

      // reset in the middle of an hsync pulse
      guard = 0;
      while (!(pixel_counter == 10'd700 && pixel_state == 2'd0) && guard < 4000) begin
         step();
         guard++;
      end
      chk("reached_pix700", 32'(guard < 4000), 32'd1);
      chk("hsync_active_pix700", 32'(hsync), 32'd0);
      reset = 1'b1;
      step();
      chk("reset_kills_hsync", 32'(hsync), 32'd1);
      step();
      reset = 1'b0;
      repeat (200) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
